// File: rtl/aes_pkg.sv
// Shared AES definitions: block size, Rcon seed, key-schedule FSM states and
// the GF(2^8) helpers that build the S-box without a lookup ROM.
package aes_pkg;

  localparam int         NB        = 4;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } ks_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int total_words(input int nr);
    return NB * (nr + 1);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; the all-zero input maps to zero as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(a, a);
    acc = sq;
    for (int k = 0; k < 6; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four independent combinational S-box lookups on a 32-bit word.
// Zero latency, no flow control; also used by the cipher SubBytes stage.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  for (genvar g = 0; g < 4; g++) begin : g_byte
    assign o_word[8*g +: 8] = sbox(i_word[8*g +: 8]);
  end

endmodule

// File: rtl/key_expansion_seq.sv
// Iterative AES key schedule: one 32-bit word per clock into a register file,
// any round key readable combinationally once the schedule is complete.
module key_expansion_seq #(
  parameter int NK = 8,
  parameter int NR = 14
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [32*NK-1:0] i_key,
  input  logic [3:0]      i_rd_round,
  output logic [127:0]    o_round_key,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_keys_valid
);
  import aes_pkg::*;

  localparam int TOTAL = total_words(NR);
  localparam int IW    = $clog2(TOTAL);

  ks_state_e       state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [2:0]      wrap_q, wrap_d;
  logic [7:0]      rcon_q, rcon_d;
  logic            done_q, done_d;
  logic            load_key;
  logic            wr_word;

  logic [31:0]     w_q [TOTAL];
  logic [31:0]     prev_w, back_w, sub_in, sub_out, temp_w, new_w;
  logic [IW-1:0]   rd_base;

  assign prev_w = w_q[idx_q - IW'(1)];
  assign back_w = w_q[idx_q - IW'(NK)];

  aes_sub_word u_sub_word (
    .i_word (sub_in),
    .o_word (sub_out)
  );

  // wrap_q tracks idx mod NK, so zero marks the RotWord/Rcon step.
  always_comb begin
    sub_in = (wrap_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    temp_w = prev_w;
    if (wrap_q == 3'd0) begin
      temp_w = sub_out ^ {rcon_q, 24'h000000};
    end else if (NK == 8 && wrap_q == 3'd4) begin
      temp_w = sub_out;
    end
    new_w = back_w ^ temp_w;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wrap_d   = wrap_q;
    rcon_d   = rcon_q;
    done_d   = 1'b0;
    load_key = 1'b0;
    wr_word  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d  = EXPAND;
          idx_d    = IW'(NK);
          wrap_d   = 3'd0;
          rcon_d   = RCON_INIT;
          load_key = 1'b1;
        end
      end
      EXPAND: begin
        wr_word = 1'b1;
        idx_d   = idx_q + IW'(1);
        wrap_d  = (wrap_q == 3'(NK - 1)) ? 3'd0 : wrap_q + 3'd1;
        if (wrap_q == 3'd0) rcon_d = xtime(rcon_q);
        if (idx_q == IW'(TOTAL - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wrap_q  <= 3'd0;
      rcon_q  <= RCON_INIT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

  // Storage carries no reset; the read port hides it until a schedule completes.
  always_ff @(posedge i_clk) begin
    if (load_key) begin
      for (int k = 0; k < NK; k++) begin
        w_q[k] <= i_key[32*NK-1-32*k -: 32];
      end
    end else if (wr_word) begin
      w_q[idx_q] <= new_w;
    end
  end

  assign rd_base = IW'({i_rd_round, 2'b00});

  always_comb begin
    o_round_key = 128'h0;
    if (state_q == DONE && i_rd_round <= 4'(NR)) begin
      o_round_key = {w_q[rd_base], w_q[rd_base + IW'(1)],
                     w_q[rd_base + IW'(2)], w_q[rd_base + IW'(3)]};
    end
  end

  assign o_busy       = (state_q == EXPAND);
  assign o_keys_valid = (state_q == DONE);
  assign o_done       = done_q;

endmodule

// File: tb/tb_key_expansion_seq.sv
// Bench: three key-size variants driven side by side, checked every cycle
// against a table-driven AES key-schedule model plus FIPS-197 vectors.
module tb_key_expansion_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]          start;
  logic [2:0][255:0]   key;
  logic [2:0][3:0]     rd;
  logic [2:0][127:0]   rk;
  logic [2:0]          busy, done, valid;

  key_expansion_seq #(.NK(4), .NR(10)) u_k4 (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_key(key[0][127:0]),
    .i_rd_round(rd[0]), .o_round_key(rk[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_keys_valid(valid[0]));
  key_expansion_seq #(.NK(6), .NR(12)) u_k6 (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_key(key[1][191:0]),
    .i_rd_round(rd[1]), .o_round_key(rk[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_keys_valid(valid[1]));
  key_expansion_seq #(.NK(8), .NR(14)) u_k8 (
    .i_clk(clk), .i_rst(rst), .i_start(start[2]), .i_key(key[2]),
    .i_rd_round(rd[2]), .o_round_key(rk[2]), .o_busy(busy[2]), .o_done(done[2]),
    .o_keys_valid(valid[2]));

  int nk_t[3]  = '{4, 6, 8};
  int nr_t[3]  = '{10, 12, 14};
  int lat_t[3] = '{40, 46, 52};

  bit [7:0]  sbox_t [256];
  bit [31:0] sched [3][60];
  bit        m_busy[3]  = '{0, 0, 0};
  bit        m_valid[3] = '{0, 0, 0};
  bit        m_done[3]  = '{0, 0, 0};
  int        m_cnt[3]   = '{0, 0, 0};
  int        checks = 0;
  int        errors = 0;

  function automatic bit [7:0] rl(bit [7:0] v, int s);
    return (v << s) | (v >> (8 - s));
  endfunction

  function automatic void build_sbox();
    bit [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    for (int i = 0; i < 255; i++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      sbox_t[p] = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4) ^ 8'h63;
    end
    sbox_t[0] = 8'h63;
  endfunction

  function automatic bit [31:0] subw(bit [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  function automatic void expand(int d, bit [255:0] kv);
    int nk, tot;
    bit [7:0]  rc;
    bit [31:0] t;
    nk  = nk_t[d];
    tot = 4 * (nr_t[d] + 1);
    rc  = 8'h01;
    for (int k = 0; k < nk; k++) sched[d][k] = kv[32*nk-1-32*k -: 32];
    for (int i = nk; i < tot; i++) begin
      t = sched[d][i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      sched[d][i] = sched[d][i-nk] ^ t;
    end
  endfunction

  function automatic bit [127:0] exp_rk(int d, int r);
    if (!m_valid[d] || r > nr_t[d]) return 128'h0;
    return {sched[d][4*r], sched[d][4*r+1], sched[d][4*r+2], sched[d][4*r+3]};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Behavioural timeline: a start in an idle/done unit takes 4*(NR+1)-NK edges.
  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_busy[d] = 0; m_valid[d] = 0; m_done[d] = 0; m_cnt[d] = 0;
      end else begin
        m_done[d] = 0;
        if (m_busy[d]) begin
          m_cnt[d]--;
          if (m_cnt[d] == 0) begin
            m_busy[d] = 0; m_valid[d] = 1; m_done[d] = 1;
          end
        end else if (start[d]) begin
          m_busy[d]  = 1;
          m_valid[d] = 0;
          m_cnt[d]   = lat_t[d];
          expand(d, key[d]);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("busy%0d", d), 128'(busy[d]), 128'(m_busy[d]));
      chk($sformatf("valid%0d", d), 128'(valid[d]), 128'(m_valid[d]));
      chk($sformatf("done%0d", d), 128'(done[d]), 128'(m_done[d]));
      chk($sformatf("rk%0d_r%0d", d, rd[d]), rk[d], exp_rk(d, int'(rd[d])));
    end
  end

  task automatic run(input int d, input logic [255:0] kv, input bit repulse, input bit rnd_rd);
    int n;
    @(posedge clk); #1;
    key[d] = kv;
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    chk($sformatf("valid_fall%0d", d), 128'(valid[d]), 128'h0);
    chk($sformatf("busy_rise%0d", d), 128'(busy[d]), 128'h1);
    n = 0;
    while (n < 300) begin
      @(posedge clk);
      n++;
      #1;
      start[d] = 1'b0;
      if (repulse && n == 10) begin
        key[d]   = ~kv;
        start[d] = 1'b1;
      end
      if (rnd_rd) rd[d] = 4'($urandom_range(0, 15));
      if (done[d]) break;
    end
    start[d] = 1'b0;
    chk($sformatf("latency%0d", d), 128'(n), 128'(lat_t[d]));
  endtask

  initial begin
    logic [255:0] rk_key;
    build_sbox();
    start = '0;
    key   = '0;
    rd    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 128'(valid), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_rk8", rk[2], 128'h0);
    rst = 1'b0;

    run(0, 256'h000102030405060708090a0b0c0d0e0f, 0, 0);
    rd[0] = 4'd10; #1;
    chk("k4_r10", rk[0], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    rd[0] = 4'd0; #1;
    chk("k4_r0", rk[0], 128'h000102030405060708090a0b0c0d0e0f);

    run(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 0, 0);
    rd[2] = 4'd1; #1;
    chk("k8_r1", rk[2], 128'h101112131415161718191a1b1c1d1e1f);
    rd[2] = 4'd14; #1;
    chk("k8_r14", rk[2], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    run(1, 256'h000102030405060708090a0b0c0d0e0f1011121314151617, 0, 0);
    rd[1] = 4'd12; #1;
    chk("k6_r12", rk[1], 128'ha4970a331a78dc09c418c271e3a41d5d);

    run(0, 256'h2b7e151628aed2a6abf7158809cf4f3c, 1, 0);
    rd[0] = 4'd1; #1;
    chk("k4_fips_r1", rk[0], 128'ha0fafe1788542cb123a339392a6c7605);
    rd[0] = 4'd11; #1;
    chk("k4_r11_zero", rk[0], 128'h0);

    // Reset twenty edges into an NK=8 expansion.
    @(posedge clk); #1;
    key[2] = {8{32'h5a5a0f0f}};
    start[2] = 1'b1;
    @(posedge clk); #1;
    start[2] = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", 128'(busy[2]), 128'h0);
    chk("abort_valid", 128'(valid[2]), 128'h0);
    chk("abort_rk", rk[2], 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    rk_key = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
    run(2, rk_key, 0, 0);
    rd[2] = 4'd14; #1;
    chk("k8_after_abort_r14", rk[2], exp_rk(2, 14));

    // Restart from DONE with a fresh key.
    rk_key = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
    run(2, rk_key, 0, 0);
    rd[2] = 4'd14; #1;
    chk("k8_restart_r14", rk[2], exp_rk(2, 14));

    for (int it = 0; it < 6; it++) begin
      int d;
      d = $urandom_range(0, 2);
      rk_key = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
      run(d, rk_key, 1'($urandom_range(0, 1)), 1);
      repeat (3) begin
        @(posedge clk); #1;
        rd[d] = 4'($urandom_range(0, 15));
      end
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
